// File: rtl/mem_access.sv
// Memory-access pipeline stage: request/acknowledge data-bus loads and stores with pipeline stall.
// Optional LL/SC link-bit support is enabled by defining LLSC_EN.
module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_wd,
    input  logic        mem_wreg,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_hi,
    input  logic [31:0] mem_lo,
    input  logic        mem_whilo,
    input  logic [7:0]  mem_aluop,
    input  logic [31:0] mem_mem_addr,
    input  logic [31:0] mem_reg2,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack,
    input  logic        llbit_clr,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_sel,
    output logic [31:0] dbus_wdata,
    output logic [4:0]  wb_wd,
    output logic        wb_wreg,
    output logic [31:0] wb_wdata,
    output logic [31:0] wb_hi,
    output logic [31:0] wb_lo,
    output logic        wb_whilo,
    output logic        stallreq_mem,
    output logic        misalign
);

    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_LL  = 8'b1111_0000;
    localparam logic [7:0] OP_SB  = 8'b1110_1000;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;
    localparam logic [7:0] OP_SC  = 8'b1111_1000;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  sel_q;
    logic        we_q;
    logic [1:0]  off_q;

    logic        is_load, is_store, sext, is_ll, is_sc, is_mem, misal, sc_fail, start;
    logic [1:0]  size;
    logic [3:0]  sel_c;
    logic [31:0] wdata_c, load_ext;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        sext     = 1'b0;
        is_ll    = 1'b0;
        is_sc    = 1'b0;
        size     = 2'd2;
        case (mem_aluop)
            OP_LB:  begin is_load = 1'b1; size = 2'd0; sext = 1'b1; end
            OP_LBU: begin is_load = 1'b1; size = 2'd0; end
            OP_LH:  begin is_load = 1'b1; size = 2'd1; sext = 1'b1; end
            OP_LHU: begin is_load = 1'b1; size = 2'd1; end
            OP_LW:  is_load = 1'b1;
            OP_LL:  begin is_load = 1'b1; is_ll = 1'b1; end
            OP_SB:  begin is_store = 1'b1; size = 2'd0; end
            OP_SH:  begin is_store = 1'b1; size = 2'd1; end
            OP_SW:  is_store = 1'b1;
            OP_SC:  begin is_store = 1'b1; is_sc = 1'b1; end
            default: ;
        endcase
    end

    assign is_mem = is_load | is_store;
    assign misal  = is_mem && (((size == 2'd1) && mem_mem_addr[0]) ||
                               ((size == 2'd2) && (mem_mem_addr[1:0] != 2'b00)));

`ifdef LLSC_EN
    logic llbit_q;

    assign sc_fail = is_sc && !llbit_q;

    // A pending clear takes priority over LL setting the link bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           llbit_q <= 1'b0;
        else if (llbit_clr)                llbit_q <= 1'b0;
        else if (state_q == DONE && is_ll) llbit_q <= 1'b1;
        else if (state_q == DONE && is_sc) llbit_q <= 1'b0;
    end
`else
    logic unused_ok;
    assign sc_fail   = 1'b0;
    assign unused_ok = &{1'b0, llbit_clr, is_ll, is_sc};
`endif

    assign start = (state_q == IDLE) && is_mem && !misal && !sc_fail;

    always_comb begin
        case (size)
            2'd0:    begin sel_c = 4'b1000 >> mem_mem_addr[1:0]; wdata_c = {4{mem_reg2[7:0]}};  end
            2'd1:    begin sel_c = mem_mem_addr[1] ? 4'b0011 : 4'b1100; wdata_c = {2{mem_reg2[15:0]}}; end
            default: begin sel_c = 4'b1111; wdata_c = mem_reg2; end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                addr_q  <= {mem_mem_addr[31:2], 2'b00};
                wdata_q <= wdata_c;
                sel_q   <= sel_c;
                we_q    <= is_store;
                off_q   <= mem_mem_addr[1:0];
            end
            if (state_q == BUSY && dbus_ack) rdata_q <= dbus_rdata;
        end
    end

    // Big-endian lane extraction from the captured read word.
    always_comb begin
        case (off_q)
            2'd0:    ld_byte = rdata_q[31:24];
            2'd1:    ld_byte = rdata_q[23:16];
            2'd2:    ld_byte = rdata_q[15:8];
            default: ld_byte = rdata_q[7:0];
        endcase
        ld_half = off_q[1] ? rdata_q[15:0] : rdata_q[31:16];
        case (size)
            2'd0:    load_ext = {{24{sext & ld_byte[7]}}, ld_byte};
            2'd1:    load_ext = {{16{sext & ld_half[15]}}, ld_half};
            default: load_ext = rdata_q;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        wb_wd        = mem_wd;
        wb_wreg      = mem_wreg;
        wb_wdata     = mem_wdata;
        wb_hi        = mem_hi;
        wb_lo        = mem_lo;
        wb_whilo     = mem_whilo;
        stallreq_mem = 1'b0;
        case (state_q)
            IDLE: begin
                if (misal) begin
                    wb_wreg = 1'b0;
                end else if (sc_fail) begin
                    wb_wdata = '0;
                end else if (is_mem) begin
                    stallreq_mem = 1'b1;
                    wb_wreg      = 1'b0;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                stallreq_mem = 1'b1;
                wb_wreg      = 1'b0;
                if (dbus_ack) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                if (is_load) begin
                    wb_wdata = load_ext;
`ifdef LLSC_EN
                end else if (is_sc) begin
                    wb_wdata = 32'd1;
`endif
                end else begin
                    wb_wreg = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dbus_req   = (state_q == BUSY);
    assign dbus_we    = we_q;
    assign dbus_addr  = addr_q;
    assign dbus_sel   = sel_q;
    assign dbus_wdata = wdata_q;
    assign misalign   = !rst && (state_q == IDLE) && misal;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with a transaction-level reference model and per-cycle compare.
module tb_mem_access;

    localparam logic [7:0] OP_LB   = 8'b1110_0000;
    localparam logic [7:0] OP_LBU  = 8'b1110_0100;
    localparam logic [7:0] OP_LH   = 8'b1110_0001;
    localparam logic [7:0] OP_LHU  = 8'b1110_0101;
    localparam logic [7:0] OP_LW   = 8'b1110_0011;
    localparam logic [7:0] OP_LL   = 8'b1111_0000;
    localparam logic [7:0] OP_SB   = 8'b1110_1000;
    localparam logic [7:0] OP_SH   = 8'b1110_1001;
    localparam logic [7:0] OP_SW   = 8'b1110_1011;
    localparam logic [7:0] OP_SC   = 8'b1111_1000;
    localparam logic [7:0] OP_ADDU = 8'b0010_0001;
`ifdef LLSC_EN
    localparam bit LLSC = 1'b1;
`else
    localparam bit LLSC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mem_wd;
    logic        mem_wreg, mem_whilo, dbus_ack, llbit_clr;
    logic [31:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_reg2, dbus_rdata;
    logic [7:0]  mem_aluop;
    logic        dbus_req, dbus_we, wb_wreg, wb_whilo, stallreq_mem, misalign;
    logic [31:0] dbus_addr, dbus_wdata, wb_wdata, wb_hi, wb_lo;
    logic [3:0]  dbus_sel;
    logic [4:0]  wb_wd;

    mem_access dut (
        .clk(clk), .rst(rst),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
        .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
        .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack), .llbit_clr(llbit_clr),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_sel(dbus_sel), .dbus_wdata(dbus_wdata),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo),
        .stallreq_mem(stallreq_mem), .misalign(misalign)
    );

    always #5 clk = ~clk;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Expected outputs for the current cycle, set by the stimulus tasks.
    logic        chk_on = 1'b0;
    logic        e_stall, e_req, e_mis, e_wreg, e_we, e_pass, e_chk_bw, e_whilo;
    logic [31:0] e_addr, e_bw, e_wb, e_hi, e_lo;
    logic [3:0]  e_sel;
    logic [4:0]  e_wd;
    bit          m_llbit = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("stallreq_mem", {31'd0, stallreq_mem}, {31'd0, e_stall});
            chk("dbus_req", {31'd0, dbus_req}, {31'd0, e_req});
            chk("misalign", {31'd0, misalign}, {31'd0, e_mis});
            chk("wb_wreg", {31'd0, wb_wreg}, {31'd0, e_wreg});
            chk("wb_wd", {27'd0, wb_wd}, {27'd0, e_wd});
            if (e_wreg) chk("wb_wdata", wb_wdata, e_wb);
            if (e_req) begin
                chk("dbus_addr", dbus_addr, e_addr);
                chk("dbus_sel", {28'd0, dbus_sel}, {28'd0, e_sel});
                chk("dbus_we", {31'd0, dbus_we}, {31'd0, e_we});
                if (e_chk_bw) chk("dbus_wdata", dbus_wdata, e_bw);
            end
            if (e_pass) begin
                chk("wb_hi", wb_hi, e_hi);
                chk("wb_lo", wb_lo, e_lo);
                chk("wb_whilo", {31'd0, wb_whilo}, {31'd0, e_whilo});
            end
        end
    end

    // 0 byte, 1 halfword, 2 word, 3 not a memory op
    function automatic int f_size(input logic [7:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 0;
            OP_LH, OP_LHU, OP_SH: return 1;
            OP_LW, OP_LL, OP_SW, OP_SC: return 2;
            default: return 3;
        endcase
    endfunction

    function automatic bit f_is_load(input logic [7:0] op);
        return op == OP_LB || op == OP_LBU || op == OP_LH || op == OP_LHU ||
               op == OP_LW || op == OP_LL;
    endfunction

    function automatic bit f_misal(input logic [7:0] op, input int off);
        int sz = f_size(op);
        return (sz == 1 && (off % 2) != 0) || (sz == 2 && off != 0);
    endfunction

    function automatic logic [3:0] f_sel(input logic [7:0] op, input int off);
        int sz = f_size(op);
        logic [3:0] one = 4'b0001;
        logic [3:0] two = 4'b0011;
        if (sz == 0) return one << (3 - off);
        if (sz == 1) return two << (2 - off);
        return 4'b1111;
    endfunction

    function automatic logic [31:0] f_bus_wdata(input logic [7:0] op, input logic [31:0] r);
        int sz = f_size(op);
        if (sz == 0) return (r & 32'hFF) * 32'h0101_0101;
        if (sz == 1) return (r & 32'hFFFF) * 32'h0001_0001;
        return r;
    endfunction

    function automatic logic [31:0] f_load(input logic [7:0] op, input int off, input logic [31:0] rd);
        logic [31:0] v;
        bit sgn = (op == OP_LB || op == OP_LH);
        if (f_size(op) == 0) begin
            v = (rd >> (8 * (3 - off))) & 32'hFF;
            if (sgn && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (f_size(op) == 1) begin
            v = (rd >> (8 * (2 - off))) & 32'hFFFF;
            if (sgn && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle_exp(input logic stall, input logic wreg, input logic mis, input logic [31:0] wb);
        e_stall = stall; e_req = 1'b0; e_mis = mis; e_wreg = wreg; e_wb = wb;
        e_pass = 1'b0; e_chk_bw = 1'b0;
    endtask

    task automatic do_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                          input logic [31:0] rdata, input int delay, input bit lit_en,
                          input logic [3:0] lit_sel, input logic [31:0] lit_bw, input logic [31:0] lit_wb);
        int  off  = int'(addr[1:0]);
        bit  load = f_is_load(op);
        mem_aluop = op; mem_mem_addr = addr; mem_reg2 = reg2;
        mem_wd = addr[6:2]; mem_wreg = 1'b1; mem_wdata = 32'h5A5A_0000 ^ addr;
        mem_whilo = 1'b0; dbus_ack = 1'b0; dbus_rdata = 32'hDEAD_BEEF;
        e_wd = addr[6:2];
        if (f_misal(op, off)) begin
            set_idle_exp(1'b0, 1'b0, 1'b1, 32'h0);
            tick();
            return;
        end
        if (LLSC && op == OP_SC && !m_llbit) begin
            set_idle_exp(1'b0, 1'b1, 1'b0, 32'h0);
            tick();
            return;
        end
        set_idle_exp(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        for (int k = 0; k <= delay; k++) begin
            dbus_ack   = (k == delay);
            dbus_rdata = (k == delay) ? rdata : 32'hDEAD_BEEF;
            e_stall = 1'b1; e_req = 1'b1; e_wreg = 1'b0; e_mis = 1'b0;
            e_addr = {addr[31:2], 2'b00}; e_sel = f_sel(op, off);
            e_we = !load; e_chk_bw = !load; e_bw = f_bus_wdata(op, reg2);
            if (k == 0 && lit_en) begin
                #1;
                chk("lit_sel", {28'd0, dbus_sel}, {28'd0, lit_sel});
                if (!load) chk("lit_bus_wdata", dbus_wdata, lit_bw);
            end
            tick();
        end
        dbus_ack = 1'b1;
        dbus_rdata = 32'h0BAD_F00D;
        if (load) begin
            set_idle_exp(1'b0, 1'b1, 1'b0, f_load(op, off, rdata));
        end else if (LLSC && op == OP_SC) begin
            set_idle_exp(1'b0, 1'b1, 1'b0, 32'd1);
        end else begin
            set_idle_exp(1'b0, 1'b0, 1'b0, 32'h0);
        end
        if (lit_en && load) begin
            #1;
            chk("lit_wb_wdata", wb_wdata, lit_wb);
        end
        tick();
        if (op == OP_LL) m_llbit = 1'b1;
        if (op == OP_SC) m_llbit = 1'b0;
        dbus_ack = 1'b0;
    endtask

    task automatic do_alu(input logic [4:0] wd, input logic [31:0] wdata, input logic [31:0] hi,
                          input logic [31:0] lo, input logic whilo, input logic wreg, input logic clr);
        mem_aluop = OP_ADDU; mem_wd = wd; mem_wdata = wdata; mem_hi = hi; mem_lo = lo;
        mem_whilo = whilo; mem_wreg = wreg; llbit_clr = clr; mem_mem_addr = 32'h0000_0003;
        set_idle_exp(1'b0, wreg, 1'b0, wdata);
        e_wd = wd; e_pass = 1'b1; e_hi = hi; e_lo = lo; e_whilo = whilo;
        tick();
        llbit_clr = 1'b0;
        if (clr) m_llbit = 1'b0;
    endtask

    task automatic reset_mid_access();
        chk_on = 1'b0;
        mem_aluop = OP_LW; mem_mem_addr = 32'h0000_6000; mem_wreg = 1'b1;
        dbus_ack = 1'b0;
        tick();
        chk("busy_req_before_rst", {31'd0, dbus_req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_req_drop", {31'd0, dbus_req}, 32'd0);
        chk("rst_sel", {28'd0, dbus_sel}, 32'd0);
        chk("rst_addr", dbus_addr, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_aluop = OP_ADDU;
        #1;
        chk("idle_after_rst_no_stall", {31'd0, stallreq_mem}, 32'd0);
        chk_on = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        mem_wd = '0; mem_wreg = 1'b0; mem_wdata = '0; mem_hi = '0; mem_lo = '0;
        mem_whilo = 1'b0; mem_aluop = OP_LW; mem_mem_addr = 32'h0000_0001; mem_reg2 = '0;
        dbus_rdata = '0; dbus_ack = 1'b0; llbit_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dbus_req", {31'd0, dbus_req}, 32'd0);
        chk("rst_dbus_we", {31'd0, dbus_we}, 32'd0);
        chk("rst_dbus_addr", dbus_addr, 32'd0);
        chk("rst_dbus_wdata", dbus_wdata, 32'd0);
        chk("rst_dbus_sel", {28'd0, dbus_sel}, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        rst = 1'b0;
        chk_on = 1'b1;

        do_mem(OP_LB,  32'h0000_1003, 32'h0, 32'h1122_33F0, 0, 1'b1, 4'b0001, 32'h0, 32'hFFFF_FFF0);
        do_mem(OP_SH,  32'h0000_2002, 32'h0000_ABCD, 32'h0, 3, 1'b1, 4'b0011, 32'hABCD_ABCD, 32'h0);
        do_mem(OP_LW,  32'h0000_3001, 32'h0, 32'h0, 0, 1'b0, 4'h0, 32'h0, 32'h0);
        do_mem(OP_LHU, 32'h0000_4000, 32'h0, 32'h8001_FFFF, 0, 1'b1, 4'b1100, 32'h0, 32'h0000_8001);
        do_alu(5'd7, 32'h1234_5678, 32'hAAAA_0001, 32'h5555_0002, 1'b1, 1'b1, 1'b0);
        do_mem(OP_SB,  32'h0000_0010, 32'h1234_56A7, 32'h0, 1, 1'b1, 4'b1000, 32'hA7A7_A7A7, 32'h0);
        do_mem(OP_LH,  32'h0000_0022, 32'h0, 32'h1234_F00D, 0, 1'b1, 4'b0011, 32'h0, 32'hFFFF_F00D);
        do_mem(OP_LBU, 32'h0000_0031, 32'h0, 32'h12C4_5678, 2, 1'b1, 4'b0100, 32'h0, 32'h0000_00C4);
        do_mem(OP_SW,  32'h0000_0044, 32'hCAFE_BABE, 32'h0, 0, 1'b1, 4'b1111, 32'hCAFE_BABE, 32'h0);
        do_mem(OP_SH,  32'h0000_7001, 32'h0, 32'h0, 0, 1'b0, 4'h0, 32'h0, 32'h0);
        do_mem(OP_LB,  32'h0000_7002, 32'h0, 32'h0000_8000, 0, 1'b1, 4'b0010, 32'h0, 32'hFFFF_FF80);
        do_mem(OP_SW,  32'h0000_7002, 32'h1, 32'h0, 0, 1'b0, 4'h0, 32'h0, 32'h0);
        reset_mid_access();
        do_mem(OP_LW,  32'h0000_8000, 32'h0, 32'h89AB_CDEF, 1, 1'b1, 4'b1111, 32'h0, 32'h89AB_CDEF);
        do_alu(5'd3, 32'h0000_0042, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
`ifdef LLSC_EN
        do_mem(OP_LL,  32'h0000_5000, 32'h0, 32'h7777_0000, 0, 1'b0, 4'h0, 32'h0, 32'h0);
        do_mem(OP_SC,  32'h0000_5000, 32'h1357_9BDF, 32'h0, 1, 1'b1, 4'b1111, 32'h1357_9BDF, 32'h0);
        do_mem(OP_SC,  32'h0000_5000, 32'h2468_ACE0, 32'h0, 0, 1'b0, 4'h0, 32'h0, 32'h0);
        do_mem(OP_LL,  32'h0000_5004, 32'h0, 32'h0000_0001, 0, 1'b0, 4'h0, 32'h0, 32'h0);
        do_alu(5'd1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        do_mem(OP_SC,  32'h0000_5004, 32'h0000_00FF, 32'h0, 0, 1'b0, 4'h0, 32'h0, 32'h0);
`else
        do_mem(OP_LL,  32'h0000_9000, 32'h0, 32'hFEDC_BA98, 0, 1'b1, 4'b1111, 32'h0, 32'hFEDC_BA98);
        do_mem(OP_SC,  32'h0000_9000, 32'h0BEE_F000, 32'h0, 1, 1'b1, 4'b1111, 32'h0BEE_F000, 32'h0);
`endif
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
